case_conv_arbiter: RTL and testbench

CASE_CONV_ARBITER -- requirements
Module: case_conv_arbiter

---
 rtl/case_conv_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_case_conv_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/case_conv_arbiter.sv
// -----------------------------------------------------------------------------
// case_conv_arbiter
//
// Purpose:
//   Two requesters offer ASCII bytes. A round-robin arbiter picks one of them
//   whenever the single output register is free. The chosen byte is converted
//   to upper case (0x61..0x7A -> minus 0x20, every other byte passes through
//   unchanged) and presented downstream one cycle after acceptance.
//
// Handshake (valid/ready, both sides):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   reqN_ready is a combinational function of the current state and the
//   request inputs, and is high for at most one requester in any cycle. Once
//   out_valid is high, out_data and out_id stay stable until a clk edge where
//   out_ready is also 1.
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   req0_valid   requester 0 offers req0_data
//   req0_data    requester 0 ASCII byte
//   req0_ready   requester 0 byte accepted this cycle
//   req1_*       same as req0_* for requester 1
//   out_valid    out_data/out_id hold a converted byte (state FULL)
//   out_data     converted byte
//   out_id       requester the byte came from
//   out_ready    downstream consumes out_data this cycle
//   last_grant   most recently granted requester (1 after reset)
//   fsm_state    debug view of the output-slot state (0 = EMPTY, 1 = FULL)
//   conv_count   saturating count of accepted lowercase bytes
//                (only when CASE_CONV_STATS_EN is defined)
//
// Parameters:
//   CNT_W        width of conv_count
//
// Configuration macro:
//   CASE_CONV_STATS_EN  adds the conv_count port and its counter register.
// -----------------------------------------------------------------------------
module case_conv_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic             out_id,
    input  logic             out_ready,
    output logic             last_grant,
    output logic             fsm_state
`ifdef CASE_CONV_STATS_EN
    ,
    output logic [CNT_W-1:0] conv_count
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic is_lower(input logic [7:0] b);
        return (b >= 8'h61) && (b <= 8'h7A);
    endfunction

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        return is_lower(b) ? (b - 8'h20) : b;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       id_q, id_d;
    logic       last_grant_q, last_grant_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic       slot_free;
    logic       grant;
    logic       grant_id;
    logic [7:0] grant_data;

    always_comb begin
        slot_free  = 1'b1;
        grant      = 1'b0;
        grant_id   = 1'b0;
        grant_data = 8'h00;

        // A FULL slot frees up in the same cycle it is consumed, which is
        // what lets back-to-back bytes flow without a bubble.
        if (state_q == ST_FULL) begin
            slot_free = out_ready;
        end

        // Gating with rst_n keeps both readies low during a reset cycle, so
        // no requester believes a byte was taken while state is being wiped.
        grant = rst_n && slot_free && (req0_valid || req1_valid);

        // Contention goes to the requester that did not win last time;
        // otherwise the only valid requester wins.
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = ~req0_valid;
        end

        grant_data = grant_id ? req1_data : req0_data;
    end

    assign req0_ready = grant && (grant_id == 1'b0);
    assign req1_ready = grant && (grant_id == 1'b1);

    // ------------------------------------------------------------------
    // Output slot FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;

        if (grant) begin
            state_d      = ST_FULL;
            data_d       = to_upper(grant_data);
            id_d         = grant_id;
            last_grant_d = grant_id;
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // ------------------------------------------------------------------
    // Output slot FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            data_q       <= 8'h00;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid  = (state_q == ST_FULL);
    assign out_data   = data_q;
    assign out_id     = id_q;
    assign last_grant = last_grant_q;
    assign fsm_state  = state_q;

    // ------------------------------------------------------------------
    // Optional statistics counter
    // ------------------------------------------------------------------
`ifdef CASE_CONV_STATS_EN
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        // Saturate rather than wrap so a long run never reports a small count.
        if (grant && is_lower(grant_data) && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign conv_count = count_q;
`endif

endmodule

// File: tb/tb_case_conv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_case_conv_arbiter
//
// Self-checking bench for case_conv_arbiter. A table of per-cycle vectors
// drives both requesters and out_ready; each entry carries the readies
// expected in that cycle and the registered outputs expected after the edge.
// Hand-written sequences follow for the randomised arbitration stream and,
// when CASE_CONV_STATS_EN is defined, the saturating counter with CNT_W=2.
// -----------------------------------------------------------------------------
module tb_case_conv_arbiter;

  localparam int CNT_W = 2;
  localparam int NVEC  = 23;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0;
  logic [7:0] req0_data = 8'h00;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic       req1_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_id;
  logic       out_ready = 1'b0;
  logic       last_grant;
  logic       fsm_state;
`ifdef CASE_CONV_STATS_EN
  logic [CNT_W-1:0] conv_count;
`endif

  case_conv_arbiter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .last_grant (last_grant),
    .fsm_state  (fsm_state)
`ifdef CASE_CONV_STATS_EN
    ,
    .conv_count (conv_count)
`endif
  );

  // ---------------- scoreboard ----------------
  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] upper_ref(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       rst_n;
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       ordy;
    logic       er0;
    logic       er1;
    logic       eov;
    logic [7:0] eod;
    logic       eid;
    logic       elg;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic r, input logic v0, input logic [7:0] d0,
                              input logic v1, input logic [7:0] d1, input logic ordy,
                              input logic er0, input logic er1, input logic eov,
                              input logic [7:0] eod, input logic eid, input logic elg);
    vec_t v;
    v.rst_n = r;  v.v0 = v0;   v.d0 = d0;   v.v1 = v1;   v.d1 = d1; v.ordy = ordy;
    v.er0 = er0;  v.er1 = er1; v.eov = eov; v.eod = eod; v.eid = eid; v.elg = elg;
    return v;
  endfunction

  task automatic drive(input logic r, input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input logic ordy);
    rst_n = r; req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1; out_ready = ordy;
  endtask

  // Model state for the randomised stream.
  logic       m_full;
  logic       m_lg;
  logic [7:0] m_data;
  logic       m_id;

  initial begin
    //                 rst v0  d0     v1  d1     ordy r0 r1 ov  od     id lg
    vecs[0]  = mk(0, 0, 8'h00, 0, 8'h00, 0,   0, 0, 0, 8'h00, 0, 1); // reset
    vecs[1]  = mk(0, 1, 8'h61, 1, 8'h62, 1,   0, 0, 0, 8'h00, 0, 1); // no ready in reset
    vecs[2]  = mk(1, 1, 8'h61, 0, 8'h00, 1,   1, 0, 1, 8'h41, 0, 0); // 'a' -> 'A'
    vecs[3]  = mk(1, 0, 8'h00, 1, 8'h5A, 1,   0, 1, 1, 8'h5A, 1, 1); // 'Z' unchanged
    vecs[4]  = mk(1, 0, 8'h00, 1, 8'h7B, 1,   0, 1, 1, 8'h7B, 1, 1); // '{' unchanged
    vecs[5]  = mk(1, 0, 8'h00, 1, 8'hE1, 1,   0, 1, 1, 8'hE1, 1, 1); // high byte unchanged
    vecs[6]  = mk(1, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 8'h00, 0, 1); // drain to EMPTY
    vecs[7]  = mk(1, 1, 8'h7A, 1, 8'h61, 0,   1, 0, 1, 8'h5A, 0, 0); // contention -> 0
    vecs[8]  = mk(1, 1, 8'h62, 1, 8'h63, 1,   0, 1, 1, 8'h43, 1, 1); // -> 1
    vecs[9]  = mk(1, 1, 8'h64, 1, 8'h65, 1,   1, 0, 1, 8'h44, 0, 0); // -> 0
    vecs[10] = mk(1, 1, 8'h66, 1, 8'h67, 1,   0, 1, 1, 8'h47, 1, 1); // -> 1
    vecs[11] = mk(1, 1, 8'h68, 1, 8'h69, 0,   0, 0, 1, 8'h47, 1, 1); // stall 1
    vecs[12] = mk(1, 1, 8'h68, 1, 8'h69, 0,   0, 0, 1, 8'h47, 1, 1); // stall 2
    vecs[13] = mk(1, 1, 8'h68, 1, 8'h69, 0,   0, 0, 1, 8'h47, 1, 1); // stall 3
    vecs[14] = mk(1, 1, 8'h68, 1, 8'h69, 1,   1, 0, 1, 8'h48, 0, 0); // release, grant same cycle
    vecs[15] = mk(1, 1, 8'h40, 0, 8'hFF, 1,   1, 0, 1, 8'h40, 0, 0); // '@' boundary
    vecs[16] = mk(1, 1, 8'h60, 0, 8'hFF, 1,   1, 0, 1, 8'h60, 0, 0); // '`' boundary
    vecs[17] = mk(1, 0, 8'h61, 1, 8'h80, 1,   0, 1, 1, 8'h80, 1, 1); // d0 ignored
    vecs[18] = mk(1, 0, 8'h61, 0, 8'h62, 0,   0, 0, 1, 8'h80, 1, 1); // hold
    vecs[19] = mk(0, 1, 8'h61, 0, 8'h00, 0,   0, 0, 0, 8'h00, 0, 1); // reset while FULL
    vecs[20] = mk(1, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 8'h00, 0, 1); // held byte gone
    vecs[21] = mk(1, 1, 8'h41, 1, 8'h7A, 1,   1, 0, 1, 8'h41, 0, 0); // first contention -> 0
    vecs[22] = mk(1, 0, 8'h00, 0, 8'h00, 1,   0, 0, 0, 8'h00, 0, 0); // drain

    // ---------------- table-driven section ----------------
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy);
      #1;
      check($sformatf("v%0d req0_ready", i), {7'b0, req0_ready}, {7'b0, vecs[i].er0});
      check($sformatf("v%0d req1_ready", i), {7'b0, req1_ready}, {7'b0, vecs[i].er1});
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), {7'b0, out_valid}, {7'b0, vecs[i].eov});
      check($sformatf("v%0d fsm_state", i), {7'b0, fsm_state}, {7'b0, vecs[i].eov});
      check($sformatf("v%0d last_grant", i), {7'b0, last_grant}, {7'b0, vecs[i].elg});
      // Data and id only matter while a byte is held, or right after reset.
      if (vecs[i].eov || !vecs[i].rst_n) begin
        check($sformatf("v%0d out_data", i), out_data, vecs[i].eod);
        check($sformatf("v%0d out_id", i), {7'b0, out_id}, {7'b0, vecs[i].eid});
      end
    end

    // ---------------- randomised arbitration stream ----------------
    @(negedge clk);
    drive(0, 0, 8'h00, 0, 8'h00, 0);
    @(posedge clk);
    m_full = 1'b0; m_lg = 1'b1; m_data = 8'h00; m_id = 1'b0;
    for (int c = 0; c < 40; c++) begin
      logic v0, v1, ordy, g, gid;
      logic [7:0] d0, d1;
      @(negedge clk);
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      d0 = 8'($urandom_range(0, 255));
      d1 = 8'($urandom_range(0, 255));
      drive(1, v0, d0, v1, d1, ordy);
      g   = (!m_full || ordy) && (v0 || v1);
      gid = (v0 && v1) ? !m_lg : !v0;
      #1;
      check("rnd req0_ready", {7'b0, req0_ready}, {7'b0, g && !gid});
      check("rnd req1_ready", {7'b0, req1_ready}, {7'b0, g && gid});
      if (g) begin
        m_full = 1'b1; m_lg = gid; m_id = gid;
        m_data = upper_ref(gid ? d1 : d0);
      end else if (m_full && ordy) begin
        m_full = 1'b0;
      end
      @(posedge clk);
      #1;
      check("rnd out_valid", {7'b0, out_valid}, {7'b0, m_full});
      check("rnd last_grant", {7'b0, last_grant}, {7'b0, m_lg});
      if (m_full) begin
        check("rnd out_data", out_data, m_data);
        check("rnd out_id", {7'b0, out_id}, {7'b0, m_id});
      end
    end

`ifdef CASE_CONV_STATS_EN
    // ---------------- saturating counter, CNT_W = 2 ----------------
    begin
      logic [7:0] exp_cnt [5];
      exp_cnt[0] = 8'd1; exp_cnt[1] = 8'd2; exp_cnt[2] = 8'd3;
      exp_cnt[3] = 8'd3; exp_cnt[4] = 8'd3;
      @(negedge clk);
      drive(0, 0, 8'h00, 0, 8'h00, 1);
      @(posedge clk);
      #1;
      check("cnt reset", {6'b0, conv_count}, 8'd0);
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        drive(1, 1, 8'h61 + 8'(k), 0, 8'h00, 1);
        @(posedge clk);
        #1;
        check($sformatf("cnt byte%0d", k), {6'b0, conv_count}, exp_cnt[k]);
      end
    end
`endif

    @(negedge clk);
    drive(1, 0, 8'h00, 0, 8'h00, 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
